// File: rtl/id_ex_stage.sv
// Operand fetch and ID/EX pipeline register: forwards operands from EX/MEM/WB,
// stalls the front end on load-use hazards and keeps stall/bubble statistics.
module id_ex_stage #(
    parameter int CTRL_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [2:0]        id_rs1,
    input  logic [2:0]        id_rs2,
    input  logic [2:0]        id_rd,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic              id_reg_wr,
    input  logic              id_mem_rd,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic [7:0]        id_imm,
    output logic [2:0]        rr1,
    output logic [2:0]        rr2,
    input  logic [7:0]        rd1,
    input  logic [7:0]        rd2,
    input  logic [7:0]        ex_result,
    input  logic [2:0]        mem_rd,
    input  logic              mem_reg_wr,
    input  logic              mem_valid,
    input  logic [7:0]        mem_data,
    input  logic [2:0]        wb_wr,
    input  logic              wb_regwr,
    input  logic [7:0]        wb_wd,
    input  logic              ex_hold,
    input  logic              flush,
    output logic              stall_id,
    output logic              ex_valid,
    output logic              ex_reg_wr,
    output logic              ex_mem_rd,
    output logic [2:0]        ex_rd,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic [7:0]        ex_op1,
    output logic [7:0]        ex_op2,
    output logic [7:0]        ex_imm,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  bubble_cnt
);

    logic              ex_valid_reg,  ex_valid_next;
    logic              ex_reg_wr_reg, ex_reg_wr_next;
    logic              ex_mem_rd_reg, ex_mem_rd_next;
    logic [2:0]        ex_rd_reg,     ex_rd_next;
    logic [CTRL_W-1:0] ex_ctrl_reg,   ex_ctrl_next;
    logic [7:0]        ex_op1_reg,    ex_op1_next;
    logic [7:0]        ex_op2_reg,    ex_op2_next;
    logic [7:0]        ex_imm_reg,    ex_imm_next;
    logic [CNT_W-1:0]  stall_cnt_reg, stall_cnt_next;
    logic [CNT_W-1:0]  bubble_cnt_reg, bubble_cnt_next;

    logic [1:0][2:0] src_idx;
    logic [1:0]      src_use;
    logic [1:0][7:0] src_rf;
    logic [1:0][7:0] src_op;
    logic [1:0]      src_hit;
    logic            ex_fwd_en;
    logic            ex_is_load;
    logic            load_use;
    logic            load_bubble;

    assign rr1     = id_rs1;
    assign rr2     = id_rs2;
    assign src_idx = {id_rs2, id_rs1};
    assign src_use = {id_use_rs2, id_use_rs1};
    assign src_rf  = {rd2, rd1};

    // A load in EX has no data yet, so it is excluded from EX forwarding.
    assign ex_fwd_en  = ex_valid_reg && ex_reg_wr_reg && !ex_mem_rd_reg;
    assign ex_is_load = ex_valid_reg && ex_reg_wr_reg && ex_mem_rd_reg && (ex_rd_reg != 3'd0);

    for (genvar gi = 0; gi < 2; gi++) begin : g_src
        assign src_op[gi] =
            (src_idx[gi] == 3'd0)                                    ? 8'h00     :
            (ex_fwd_en && ex_rd_reg == src_idx[gi])                  ? ex_result :
            (mem_valid && mem_reg_wr && mem_rd == src_idx[gi])       ? mem_data  :
            (wb_regwr && wb_wr == src_idx[gi] && wb_wr != 3'd0)      ? wb_wd     :
                                                                       src_rf[gi];
        assign src_hit[gi] = src_use[gi] && (src_idx[gi] == ex_rd_reg);
    end

    assign load_use    = id_valid && ex_is_load && (|src_hit);
    assign stall_id    = load_use || ex_hold;
    assign load_bubble = flush || load_use || !id_valid;

    always_comb begin
        ex_valid_next   = ex_valid_reg;
        ex_reg_wr_next  = ex_reg_wr_reg;
        ex_mem_rd_next  = ex_mem_rd_reg;
        ex_rd_next      = ex_rd_reg;
        ex_ctrl_next    = ex_ctrl_reg;
        ex_op1_next     = ex_op1_reg;
        ex_op2_next     = ex_op2_reg;
        ex_imm_next     = ex_imm_reg;
        stall_cnt_next  = stall_cnt_reg;
        bubble_cnt_next = bubble_cnt_reg;
        if (!ex_hold) begin
            if (flush || load_use) begin
                ex_valid_next  = 1'b0;
                ex_reg_wr_next = 1'b0;
                ex_mem_rd_next = 1'b0;
                ex_rd_next     = 3'd0;
                ex_ctrl_next   = '0;
                ex_op1_next    = 8'h00;
                ex_op2_next    = 8'h00;
                ex_imm_next    = 8'h00;
            end else begin
                ex_valid_next  = id_valid;
                ex_reg_wr_next = id_valid && id_reg_wr;
                ex_mem_rd_next = id_valid && id_mem_rd;
                ex_rd_next     = id_rd;
                ex_ctrl_next   = id_valid ? id_ctrl : '0;
                ex_op1_next    = src_op[0];
                ex_op2_next    = src_op[1];
                ex_imm_next    = id_imm;
            end
            // Statistics saturate rather than wrap.
            if (load_use && stall_cnt_reg != '1)
                stall_cnt_next = stall_cnt_reg + CNT_W'(1);
            if (load_bubble && bubble_cnt_reg != '1)
                bubble_cnt_next = bubble_cnt_reg + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid_reg   <= 1'b0;
            ex_reg_wr_reg  <= 1'b0;
            ex_mem_rd_reg  <= 1'b0;
            ex_rd_reg      <= 3'd0;
            ex_ctrl_reg    <= '0;
            ex_op1_reg     <= 8'h00;
            ex_op2_reg     <= 8'h00;
            ex_imm_reg     <= 8'h00;
            stall_cnt_reg  <= '0;
            bubble_cnt_reg <= '0;
        end else begin
            ex_valid_reg   <= ex_valid_next;
            ex_reg_wr_reg  <= ex_reg_wr_next;
            ex_mem_rd_reg  <= ex_mem_rd_next;
            ex_rd_reg      <= ex_rd_next;
            ex_ctrl_reg    <= ex_ctrl_next;
            ex_op1_reg     <= ex_op1_next;
            ex_op2_reg     <= ex_op2_next;
            ex_imm_reg     <= ex_imm_next;
            stall_cnt_reg  <= stall_cnt_next;
            bubble_cnt_reg <= bubble_cnt_next;
        end
    end

    assign ex_valid   = ex_valid_reg;
    assign ex_reg_wr  = ex_reg_wr_reg;
    assign ex_mem_rd  = ex_mem_rd_reg;
    assign ex_rd      = ex_rd_reg;
    assign ex_ctrl    = ex_ctrl_reg;
    assign ex_op1     = ex_op1_reg;
    assign ex_op2     = ex_op2_reg;
    assign ex_imm     = ex_imm_reg;
    assign stall_cnt  = stall_cnt_reg;
    assign bubble_cnt = bubble_cnt_reg;

endmodule
